// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH cycles per
// division; a zero divisor short-circuits to all-ones quotient with div_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  // The partial remainder always stays below the divisor, so it is stored in
  // WIDTH bits; only the shifted value needs the extra top bit.
  logic [WIDTH:0]   w_pr_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_pr_next;
  logic [WIDTH-1:0] w_sr_next;

  assign w_pr_shift = {r_pr, r_sr[WIDTH-1]};
  assign w_ge       = (w_pr_shift >= {1'b0, r_dvsr});
  assign w_diff     = w_pr_shift[WIDTH-1:0] - r_dvsr;
  assign w_pr_next  = w_ge ? w_diff : w_pr_shift[WIDTH-1:0];
  assign w_sr_next  = {r_sr[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pr    <= '0;
      r_sr    <= '0;
      r_dvsr  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_dvsr  <= divisor;
              r_pr    <= '0;
              r_sr    <= dividend;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end else begin
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_pr  <= w_pr_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_quot  <= w_sr_next;
            r_rem   <= w_pr_next;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // A zero-divisor result arrives here with done low and pulses it
          // on the following cycle; a computed result arrives with it high.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver predicts acceptance and results
// with plain arithmetic, a negedge monitor pops and compares on each done.
module tb_seq_divider;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int at_edge;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   next_idle = 0;
  int   busy_lo = 0;
  int   busy_hi = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: behaviour of one accepted request at edge k.
  task automatic accept(input int a, input int b, input int k);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = MAXV; e.r = a; e.dz = 1; e.at_edge = k + 1;
      next_idle = k + 3;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0; e.at_edge = k + W;
      busy_lo = k;
      busy_hi = k + W;
      next_idle = k + W + 2;
    end
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input bit st, input int a, input int b, output bit acc);
    @(negedge clk);
    start    = st;
    dividend = W'(a);
    divisor  = W'(b);
    acc = 1'b0;
    if (st && !rst && (cyc + 1) >= next_idle) begin
      accept(a, b, cyc + 1);
      acc = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, $urandom_range(0, MAXV), $urandom_range(0, MAXV), acc);
  endtask

  task automatic one_op(input int a, input int b);
    bit acc;
    acc = 1'b0;
    while (!acc) drive_cycle(1'b1, a, b, acc);
    idle_cycles(W + 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_div_zero"}, int'(div_zero), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy_window", int'(busy), int'(cyc >= busy_lo && cyc < busy_hi));
      chk("busy_done_excl", int'(busy & done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at_edge);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_zero", int'(div_zero), e.dz);
          if (e.b != 0) begin
            chk("identity", int'(quotient) * e.b + int'(remainder), e.a);
            chk("rem_lt_div", int'(int'(remainder) < e.b), 1);
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    rst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #1 rst = 1'b1;
    #3 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    one_op(13, 4);
    one_op(7, 0);
    one_op(15, 1);
    one_op(3, 15);
    one_op(0, 5);

    // Start held high, operands changing every cycle.
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b1, $urandom_range(0, MAXV), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXV), acc);
    idle_cycles(W + 3);

    // Reset during the second CALC cycle of 9/2.
    acc = 1'b0;
    while (!acc) drive_cycle(1'b1, 9, 2, acc);
    drive_cycle(1'b0, 5, 3, acc);
    drive_cycle(1'b0, 6, 1, acc);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_calc_rst");
    sb.delete();
    busy_lo = 0;
    busy_hi = 0;
    next_idle = 0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    idle_cycles(W + 4);
    one_op(9, 2);

    for (int a = 0; a <= MAXV; a++)
      for (int b = 0; b <= MAXV; b++) begin
        acc = 1'b0;
        while (!acc) drive_cycle(1'b1, a, b, acc);
      end
    idle_cycles(W + 4);
    chk("pending_results", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have exactly one clock and use an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 4, operand/result width in bits; all values below assume WIDTH=4.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  WIDTH  unsigned numerator; sampled when start is accepted.
REQ-007 divisor  input  WIDTH  unsigned denominator; sampled when start is accepted.
REQ-008 quotient  output  WIDTH  registered result; held until the next accepted start completes.
REQ-009 remainder  output  WIDTH  registered result; held likewise.
REQ-010 busy  output  1  high while a division is in progress (CALC state).
REQ-011 done  output  1  one-cycle pulse marking that quotient and remainder are valid.
REQ-012 div_zero  output  1  registered flag; set with done when divisor was 0; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE, with CALC using an iteration counter of ceil(log2(WIDTH)) bits.
REQ-014 IDLE with start=1 and divisor!=0: latch the operands, clear the partial remainder (WIDTH+1 bits), set the shift register to dividend, clear the counter and go to CALC.
REQ-015 IDLE with start=1 and divisor==0: go directly to DONE and register quotient={WIDTH{1}}, remainder=dividend, div_zero=1.
REQ-016 Each CALC cycle SHALL perform one restoring step:
  - shift the partial remainder left, taking in the shift-register MSB;
  - shift the shift register left;
  - if the partial remainder >= the latched divisor, subtract the divisor and set shift-register bit 0 to 1, else set it to 0.
REQ-017 CALC SHALL last exactly WIDTH cycles; on the last step, register quotient and remainder[WIDTH-1:0], clear div_zero and go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-019 start SHALL be ignored in CALC and DONE, and a start request SHALL NOT be queued.
REQ-020 Timing: start is accepted at edge k; busy is 1 from edge k to edge k+WIDTH; done is 1 from edge k+WIDTH to k+WIDTH+1. With divisor 0, done is 1 from edge k+1 to k+2.
REQ-021 Inputs dividend and divisor MAY change after acceptance without affecting the result in progress.
REQ-022 Results SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor for all divisor!=0.
REQ-023 busy and done SHALL never be 1 simultaneously.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and counter=0, and set quotient=0, remainder=0, busy=0, done=0 and div_zero=0.
REQ-025 Reset asserted mid-CALC SHALL abandon the operation; no done pulse follows after release.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 start, dividend=13, divisor=4 -> busy high for 4 cycles; then done pulse with quotient=3, remainder=1, div_zero=0.
REQ-028 start, dividend=7, divisor=0 -> done one cycle after acceptance; quotient=15, remainder=7, div_zero=1, busy never high.
REQ-029 Boundary operands:
  - dividend=15, divisor=1 -> quotient=15, remainder=0;
  - dividend=3, divisor=15 -> quotient=0, remainder=3;
  - dividend=0, divisor=5 -> quotient=0, remainder=0.
REQ-030 start held high continuously with operands changing every cycle -> only the IDLE-sampled operands are used; back-to-back operations are spaced WIDTH+2 cycles apart; results are correct.
REQ-031 rst pulse during the 2nd CALC cycle of 9/2 -> outputs are 0 immediately and no done follows; a subsequent 9/2 gives quotient=4, remainder=1.
REQ-032 Exhaustive sweep of all 256 operand pairs against a reference model checking REQ-022 and REQ-023.
